// File: rtl/crc_frame_pkg.sv
// -----------------------------------------------------------------------------
// crc_frame_pkg
// Shared definitions for the CRC-protected frame memory. The writer
// (crc_frame_writer) and the CRC-checking reader both use these.
//   - frame tag constants carried in dataout[15:14]
//   - default message/CRC widths and the generator polynomial
//   - writer FSM state type
//   - tag selection helper
// -----------------------------------------------------------------------------
package crc_frame_pkg;

  localparam int unsigned DEF_MESS_LEN = 10;
  localparam int unsigned DEF_CRC_LEN  = 4;
  // x^4 + x + 1; the MSB is the implicit x^4 term and never enters the XOR.
  localparam logic [4:0]  DEF_POLY     = 5'b10011;
  localparam int unsigned ADDR_W       = 5;

  localparam logic [1:0] TAG_IDLE  = 2'b00;
  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b10;
  localparam logic [1:0] TAG_LAST  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    WRITE = 2'b10
  } state_e;

  // Last wins over first, so a single-word frame is tagged TAG_LAST.
  function automatic logic [1:0] select_tag(input logic is_last, input logic is_first);
    if (is_last) begin
      return TAG_LAST;
    end else if (is_first) begin
      return TAG_FIRST;
    end
    return TAG_MID;
  endfunction

endpackage

// File: rtl/crc_serial_step.sv
// -----------------------------------------------------------------------------
// crc_serial_step
// One bit of serial polynomial division (MSB-first LFSR step). Purely
// combinational so the reader can reuse it for a bit-serial check.
// Ports:
//   crc_i      current remainder
//   bit_i      next message bit
//   poly_i     generator polynomial without its implicit top term
//   next_crc_o remainder after absorbing bit_i
// -----------------------------------------------------------------------------
module crc_serial_step #(
  parameter int unsigned CRC_LEN = 4
) (
  input  logic [CRC_LEN-1:0] crc_i,
  input  logic               bit_i,
  input  logic [CRC_LEN-1:0] poly_i,
  output logic [CRC_LEN-1:0] next_crc_o
);

  logic fb;

  assign fb         = crc_i[CRC_LEN-1] ^ bit_i;
  assign next_crc_o = {crc_i[CRC_LEN-2:0], 1'b0} ^ (fb ? poly_i : '0);

endmodule

// File: rtl/crc_frame_writer.sv
// -----------------------------------------------------------------------------
// crc_frame_writer
// Transmit-side framer: accepts messages over valid/ready, computes a CRC one
// bit per cycle and writes {tag, msg, crc} into the 32-word frame RAM.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   msg_data, msg_last  message and end-of-frame marker, sampled on handshake
//   msg_valid/msg_ready upstream handshake (msg_ready is registered)
//   address, wren,      RAM write port; wren is a one-cycle pulse and
//   dataout             dataout holds its last written value otherwise
//   tick_DONE           pulses with wren on the last word of a frame
//   overflow            sticky: a frame ran past 32 words
// -----------------------------------------------------------------------------
module crc_frame_writer
  import crc_frame_pkg::*;
#(
  parameter int unsigned        MESS_LEN  = DEF_MESS_LEN,
  parameter int unsigned        CRC_LEN   = DEF_CRC_LEN,
  parameter logic [CRC_LEN:0]   POLY      = DEF_POLY,
  parameter logic [ADDR_W-1:0]  ADDR_INIT = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MESS_LEN-1:0]         msg_data,
  input  logic                        msg_last,
  input  logic                        msg_valid,
  output logic                        msg_ready,
  output logic [ADDR_W-1:0]           address,
  output logic                        wren,
  output logic [MESS_LEN+CRC_LEN+1:0] dataout,
  output logic                        tick_DONE,
  output logic                        overflow
);

  localparam int unsigned CNT_W  = $clog2(MESS_LEN);
  localparam int unsigned WORD_W = MESS_LEN + CRC_LEN + 2;

  state_e              state_q, state_d;
  logic [MESS_LEN-1:0] msg_q, msg_d;
  logic [MESS_LEN-1:0] shift_q, shift_d;
  logic                last_q, last_d;
  logic [CRC_LEN-1:0]  crc_q, crc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_inc;
  logic                wren_q, wren_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                tick_q, tick_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic [CRC_LEN-1:0]  crc_step;

  // Message bits are consumed MSB first from a private shift copy so msg_q
  // stays intact for the written word.
  crc_serial_step #(
    .CRC_LEN (CRC_LEN)
  ) u_step (
    .crc_i      (crc_q),
    .bit_i      (shift_q[MESS_LEN-1]),
    .poly_i     (POLY[CRC_LEN-1:0]),
    .next_crc_o (crc_step)
  );

  assign addr_inc = addr_q + 1'b1;

  always_comb begin
    // NOTE: every variable gets its hold value first; a path that leaves one
    // unassigned would infer a latch.
    state_d = state_q;
    msg_d   = msg_q;
    shift_d = shift_q;
    last_d  = last_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    wren_d  = 1'b0;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (msg_valid && ready_q) begin
          msg_d   = msg_data;
          shift_d = msg_data;
          last_d  = msg_last;
          crc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        crc_d   = crc_step;
        shift_d = {shift_q[MESS_LEN-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MESS_LEN - 1)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wren_d  = 1'b1;
        tick_d  = last_q;
        data_d  = {select_tag(last_q, first_q), msg_q, crc_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address and frame bookkeeping happen in the cycle after the write so
    // that address is stable for the whole wren pulse.
    if (wren_q) begin
      if (last_q) begin
        addr_d  = ADDR_INIT;
        first_d = 1'b1;
      end else begin
        addr_d  = addr_inc;
        first_d = 1'b0;
        // Coming back round to the frame start means 32 words were written.
        if (addr_inc == ADDR_INIT) begin
          ovf_d = 1'b1;
        end
      end
    end

    // Held low through the write cycle, so ready rises one cycle after wren.
    ready_d = (state_d == IDLE) && (state_q != WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      crc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      addr_q  <= ADDR_INIT;
      wren_q  <= 1'b0;
      data_q  <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      msg_q   <= msg_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  assign msg_ready = ready_q;
  assign address   = addr_q;
  assign wren      = wren_q;
  assign dataout   = data_q;
  assign tick_DONE = tick_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_crc_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_writer
// Self-checking bench: a table of known words, hand-built corner sequences
// (overflow, reset mid-CALC) and random messages against a reference model
// that computes the CRC by long division of msg*x^4 by the polynomial.
// -----------------------------------------------------------------------------
module tb_crc_frame_writer;
  import crc_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  msg_data;
  logic        msg_last;
  logic        msg_valid;
  logic        msg_ready;
  logic [4:0]  address;
  logic        wren;
  logic [15:0] dataout;
  logic        tick_DONE;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [4:0] m_addr;
  logic       m_first;
  logic       m_ovf;

  typedef struct {
    logic [9:0]  msg;
    logic        last;
    logic [15:0] exp_word;
    logic [4:0]  exp_addr;
    logic        exp_tick;
  } vec_t;

  vec_t vecs[6];

  crc_frame_writer dut (
    .clk       (clk),
    .rst       (rst),
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .address   (address),
    .wren      (wren),
    .dataout   (dataout),
    .tick_DONE (tick_DONE),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Remainder of msg*x^4 divided by x^4+x+1, by plain long division.
  function automatic logic [3:0] ref_crc(input logic [9:0] m);
    logic [13:0] r;
    r = {m, 4'b0000};
    for (int i = 13; i >= 4; i--) begin
      if (r[i]) r = r ^ (14'h13 << (i - 4));
    end
    return r[3:0];
  endfunction

  function automatic logic [15:0] model_word(input logic [9:0] m, input logic l);
    logic [1:0] tag;
    tag = l ? TAG_LAST : (m_first ? TAG_FIRST : TAG_MID);
    return {tag, m, ref_crc(m)};
  endfunction

  task automatic model_reset();
    m_addr  = 5'd0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_advance(input logic l);
    if (l) begin
      m_addr  = 5'd0;
      m_first = 1'b1;
    end else begin
      m_addr  = m_addr + 5'd1;
      m_first = 1'b0;
      if (m_addr == 5'd0) m_ovf = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/msg_ready"}, 32'(msg_ready), 32'd0);
    check({name, "/address"},   32'(address),   32'd0);
    check({name, "/wren"},      32'(wren),      32'd0);
    check({name, "/dataout"},   32'(dataout),   32'd0);
    check({name, "/tick_DONE"}, 32'(tick_DONE), 32'd0);
    check({name, "/overflow"},  32'(overflow),  32'd0);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Sends one message and observes it through to msg_ready returning.
  // Busy cycles carry junk valid/data that the block must ignore.
  task automatic send_msg(input string name, input logic [9:0] m, input logic l,
                          output logic [15:0] word, output logic [4:0] addr,
                          output logic tick);
    int n, lat, pulses, stray;
    n = 0;
    while (!msg_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "/ready_wait"}, 32'(msg_ready), 32'd1);
    msg_data  = m;
    msg_last  = l;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    n = 0; lat = -1; pulses = 0; stray = 0;
    word = '0; addr = '0; tick = 1'b0;
    while (!msg_ready && n < 40) begin
      if (wren) begin
        lat = n; pulses++;
        word = dataout; addr = address; tick = tick_DONE;
      end else if (tick_DONE) begin
        stray++;
      end
      msg_valid = 1'($urandom_range(0, 1));
      msg_data  = 10'($urandom);
      msg_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    msg_valid = 1'b0;
    check({name, "/latency"},    32'(lat),    32'd11);
    check({name, "/ready_low"},  32'(n),      32'd12);
    check({name, "/wren_count"}, 32'(pulses), 32'd1);
    check({name, "/stray_tick"}, 32'(stray),  32'd0);
    check({name, "/data_hold"},  32'(dataout), 32'(word));
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  a;
    logic        t;
    logic [9:0]  m;
    logic        l;
    int          wr_seen;

    vecs[0] = '{10'h200, 1'b0, 16'h600D, 5'd0, 1'b0};
    vecs[1] = '{10'h001, 1'b1, 16'hC013, 5'd1, 1'b1};
    vecs[2] = '{10'h000, 1'b1, 16'hC000, 5'd0, 1'b1};
    vecs[3] = '{10'h000, 1'b0, 16'h4000, 5'd0, 1'b0};
    vecs[4] = '{10'h000, 1'b0, 16'h8000, 5'd1, 1'b0};
    vecs[5] = '{10'h001, 1'b1, 16'hC013, 5'd2, 1'b1};

    msg_data = '0;
    msg_last = 1'b0;
    rst      = 1'b1;
    msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Known words: test-plan frames and a three-word 01/10/11 frame.
    for (int i = 0; i < 6; i++) begin
      send_msg($sformatf("vec%0d", i), vecs[i].msg, vecs[i].last, w, a, t);
      check($sformatf("vec%0d/word", i), 32'(w), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d/addr", i), 32'(a), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d/tick", i), 32'(t), 32'(vecs[i].exp_tick));
      model_advance(vecs[i].last);
      check($sformatf("vec%0d/next_addr", i), 32'(address), 32'(m_addr));
    end

    // 33 non-last words: the 33rd wraps to address 0 tagged middle.
    apply_reset();
    for (int i = 0; i < 33; i++) begin
      m = 10'($urandom);
      send_msg($sformatf("ovf%0d", i), m, 1'b0, w, a, t);
      check($sformatf("ovf%0d/word", i), 32'(w), 32'(model_word(m, 1'b0)));
      check($sformatf("ovf%0d/addr", i), 32'(a), 32'(m_addr));
      model_advance(1'b0);
      check($sformatf("ovf%0d/overflow", i), 32'(overflow), 32'(m_ovf));
    end
    check("ovf32/addr_zero", 32'(a), 32'd0);
    check("ovf32/tag_mid", 32'(w[15:14]), 32'(TAG_MID));
    check("ovf/flag_set", 32'(overflow), 32'd1);
    send_msg("ovf_close", 10'h155, 1'b1, w, a, t);
    check("ovf_close/tick", 32'(t), 32'd1);
    check("ovf/sticky", 32'(overflow), 32'd1);

    // Reset during the 5th CALC cycle abandons the message.
    wr_seen = 0;
    while (!msg_ready) @(negedge clk);
    msg_data  = 10'h3A5;
    msg_last  = 1'b1;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wren) wr_seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midcalc_rst");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (wren) wr_seen++;
      @(negedge clk);
    end
    check("midcalc_rst/no_write", 32'(wr_seen), 32'd0);
    model_reset();
    send_msg("after_rst", 10'h000, 1'b0, w, a, t);
    check("after_rst/word", 32'(w), 32'h4000);
    check("after_rst/addr", 32'(a), 32'd0);
    model_advance(1'b0);

    // Random messages against the model.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      m = 10'($urandom);
      l = ($urandom_range(0, 3) == 0);
      send_msg($sformatf("rnd%0d", i), m, l, w, a, t);
      check($sformatf("rnd%0d/word", i), 32'(w), 32'(model_word(m, l)));
      check($sformatf("rnd%0d/addr", i), 32'(a), 32'(m_addr));
      check($sformatf("rnd%0d/tick", i), 32'(t), 32'(l));
      model_advance(l);
      check($sformatf("rnd%0d/overflow", i), 32'(overflow), 32'(m_ovf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
